word_packer: RTL and testbench
==============================

// Module: word_packer
// PURPOSE
//   Streaming front end for the tree_adder reduction path: gathers SIZE words of
//   WIDTH bits from a valid/ready stream into the packed WIDTH*SIZE vector that
//   tree_adder consumes. It presents the packed frame with a valid/ready
//   handshake. Short frames, terminated early by in_last, are zero-padded.
// PARAMETERS
//   WIDTH  8  bits per word
//   SIZE   4  words per frame (>=1)
//   CNT_W  $clog2(SIZE+1)  width of out_count (derived, do not override)
// PORTS
//   clk        in   1             single clock, rising edge
//   rst_n      in   1             asynchronous, active-low reset
//   in_data    in   WIDTH         input word
//   in_valid   in   1             in_data valid
//   in_last    in   1             final word of frame (qualified by in_valid)
//   in_ready   out  1             packer can accept a word
//   out_data   out  WIDTH*SIZE    packed frame; word k at [WIDTH*k +: WIDTH]
//   out_count  out  CNT_W         number of real words in frame (1..SIZE)
//   out_valid  out  1             frame valid
//   out_ready  in   1             downstream accepts frame
//   sum_out    out  WIDTH         only with PACKER_SUM_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=FILL, write index=0, out_data=0,
//     out_count=0, out_valid=0, in_ready=0 while rst_n low; sum_out=0 if present.
//   - FILL: in_ready=1, out_valid=0. An input beat occurs when in_valid&&in_ready;
//     the word is written to slot idx, and idx increments.
//   - The first accepted word lands in bits [WIDTH-1:0]; later words go to
//     progressively higher slots.
//   - FILL->HOLD when a beat has in_last=1 or fills slot SIZE-1, whichever
//     comes first. out_count=idx+1; slots above idx stay 0.
//   - out_valid=1 in the cycle after the closing beat (latency 1 clk).
//   - HOLD: in_ready=0, out_valid=1; out_data, out_count and sum_out stay stable
//     until out_valid&&out_ready.
//   - HOLD->FILL on out_valid&&out_ready. In the next cycle the packer clears
//     out_data, sets idx=0 and out_count=0. It takes no input during the
//     handshake cycle.
//   - in_last on the SIZE-th word is the same as a full frame.
//   - in_last is ignored unless in_valid=1.
//   - SIZE=1: every beat closes a frame. Throughput is 1 frame per 2 clk when
//     out_ready is tied high.
//   - in_data/in_last are don't-care when in_valid=0. The block issues no
//     backpressure violations: once out_valid rises, it holds it until
//     accepted.
//   - rst_n asserted mid-frame or in HOLD: the frame is discarded and all
//     state returns to reset values immediately. There is no partial output.
//   - idx never exceeds SIZE-1; no wrap-around past the frame boundary.
// CONFIGURATION
//   PACKER_SUM_EN defined: port sum_out is present. It is the running sum of
//     accepted words modulo 2^WIDTH, updated on each input beat and cleared
//     with the frame. It is valid and stable when out_valid=1. It equals the
//     tree_adder result on out_data.
//   PACKER_SUM_EN undefined: port sum_out and its adder are absent. All other
//     behaviour is identical.
// TESTING
//   1 reset: rst_n=0 -> out_valid=0, in_ready=0, out_data=0, out_count=0;
//     release -> in_ready=1.
//   2 full frame: send 04,03,02,01 with out_ready=1 -> out_data=32'h01020304,
//     out_count=4, out_valid 1 clk after 4th beat, sum_out=8'h0A.
//   3 overflow: send FF x4 -> out_data=32'hFFFFFFFF, sum_out=8'hFC.
//   4 short frame: send 05 with in_last=1 -> out_data=32'h00000005,
//     out_count=1, sum_out=8'h05.
//   5 backpressure: frame 03,02+last with out_ready=0 for 5 clk ->
//     out_valid/out_data=32'h00000203 stable, in_ready=0, extra in_valid beats
//     not accepted; then out_ready=1 -> next cycle FILL, out_data=0.
//   6 reset mid-frame: 2 words accepted, pulse rst_n low -> next frame
//     01,01,01,01 gives out_data=32'h01010101 (no stale words).

Source files
------------

// File: rtl/word_packer_if.sv
// Stream bundle for word_packer: word input stream plus packed-frame output stream.
// sum_out exists only when PACKER_SUM_EN is defined.
interface word_packer_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4
);
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [WIDTH*SIZE-1:0] out_data;
  logic [CNT_W-1:0]      out_count;
  logic                  out_valid;
  logic                  out_ready;
`ifdef PACKER_SUM_EN
  logic [WIDTH-1:0]      sum_out;
`endif

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
`ifdef PACKER_SUM_EN
    output sum_out,
`endif
    output in_ready, out_data, out_count, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
`ifdef PACKER_SUM_EN
    input  sum_out,
`endif
    input  in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/word_packer.sv
// Gathers up to SIZE words into one zero-padded packed frame with valid/ready on both sides.
// Optional running-sum output sum_out is enabled by defining PACKER_SUM_EN.
module word_packer #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  word_packer_if.slave bus
);
  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [WIDTH*SIZE-1:0] r_data;
  logic [CNT_W-1:0]      r_count;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  w_beat;
  logic                  w_close;
  logic                  w_accept;

  assign w_beat   = bus.in_valid && r_in_ready;
  // A frame closes on in_last or when the top slot is written, whichever is first.
  assign w_close  = bus.in_last || (r_idx == IDX_W'(SIZE - 1));
  assign w_accept = r_out_valid && bus.out_ready;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  // NOTE: the frame buffer is a plain flop vector and is reset so cleared slots read as zero padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            r_data[WIDTH*r_idx +: WIDTH] <= bus.in_data;
            if (w_close) begin
              r_state     <= HOLD;
              r_count     <= CNT_W'(r_idx) + CNT_W'(1);
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_data;
  assign bus.out_count = r_count;
  assign bus.out_valid = r_out_valid;

`ifdef PACKER_SUM_EN
  logic [WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_beat) begin
      r_sum <= r_sum + bus.in_data;
    end
  end

  assign bus.sum_out = r_sum;
`endif
endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: table of frames plus backpressure and mid-frame reset sequences.
module tb_word_packer;
  localparam int WIDTH = 8;
  localparam int SIZE  = 4;

  typedef struct {
    logic [3:0][7:0] w;
    int              n_words;
    logic            last_at_end;
    logic [31:0]     exp_data;
    logic [31:0]     exp_count;
    logic [31:0]     exp_sum;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t vecs [6];

  word_packer_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  word_packer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the beat's posedge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_post_data"},  bus.out_data, 32'd0);
    check({tag, "_post_count"}, {29'd0, bus.out_count}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] d, input logic [31:0] c,
                             input logic [31:0] s);
    check({tag, "_valid"},   {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_inready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_data"},    bus.out_data, d);
    check({tag, "_count"},   {29'd0, bus.out_count}, c);
`ifdef PACKER_SUM_EN
    check({tag, "_sum"},     {24'd0, bus.sum_out}, s);
`else
    if (s === 32'hx) $display("unused sum %h", s);
`endif
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{w: {8'h01, 8'h02, 8'h03, 8'h04}, n_words: 4, last_at_end: 1'b0,
                exp_data: 32'h01020304, exp_count: 4, exp_sum: 32'h0A};
    vecs[1] = '{w: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, n_words: 4, last_at_end: 1'b0,
                exp_data: 32'hFFFFFFFF, exp_count: 4, exp_sum: 32'hFC};
    vecs[2] = '{w: {8'h00, 8'h00, 8'h00, 8'h05}, n_words: 1, last_at_end: 1'b1,
                exp_data: 32'h00000005, exp_count: 1, exp_sum: 32'h05};
    vecs[3] = '{w: {8'h00, 8'h33, 8'h22, 8'h11}, n_words: 3, last_at_end: 1'b1,
                exp_data: 32'h00332211, exp_count: 3, exp_sum: 32'h66};
    vecs[4] = '{w: {8'h00, 8'h00, 8'h55, 8'hAA}, n_words: 2, last_at_end: 1'b1,
                exp_data: 32'h000055AA, exp_count: 2, exp_sum: 32'hFF};
    vecs[5] = '{w: {8'h40, 8'h30, 8'h20, 8'h10}, n_words: 4, last_at_end: 1'b1,
                exp_data: 32'h40302010, exp_count: 4, exp_sum: 32'hA0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_data",  bus.out_data, 32'd0);
    check("rst_count", {29'd0, bus.out_count}, 32'd0);
`ifdef PACKER_SUM_EN
    check("rst_sum",   {24'd0, bus.sum_out}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, bus.in_ready}, 32'd1);

    // Table of frames
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n_words; k++) begin
        if (k == vecs[i].n_words - 1)
          check($sformatf("v%0d_pre_valid", i), {31'd0, bus.out_valid}, 32'd0);
        send(vecs[i].w[k], (k == vecs[i].n_words - 1) ? vecs[i].last_at_end : 1'b0);
      end
      check_frame($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_count, vecs[i].exp_sum);
      handshake($sformatf("v%0d", i));
    end

    // Backpressure: frame held while extra input beats are offered
    send(8'h03, 1'b0);
    send(8'h02, 1'b1);
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_frame($sformatf("bp%0d", c), 32'h00000203, 32'd2, 32'h05);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_post_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_post_data",  bus.out_data, 32'd0);
    check("bp_post_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'h01, 1'b1);
    check_frame("bp_next", 32'h00000001, 32'd1, 32'h01);
    handshake("bp_next");

    // Reset in the middle of a frame
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  bus.out_data, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) send(8'h01, 1'b0);
    check_frame("mid_next", 32'h01010101, 32'd4, 32'h04);
    handshake("mid_next");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
